// File: rtl/vga_pkg.sv
// Shared constants and pipeline payload types for the VGA text scan-out.
// Contents: text-grid geometry, visible-area size, character-code constants,
// and the sideband struct that travels alongside the RAM/ROM read pipeline.
package vga_pkg;

    localparam int unsigned TEXT_COLS  = 80;
    localparam int unsigned TEXT_ROWS  = 24;
    localparam int unsigned CELL_W     = 8;
    localparam int unsigned CELL_H     = 20;
    localparam int unsigned GLYPH_H    = 16;
    localparam int unsigned CHAR_COUNT = TEXT_COLS * TEXT_ROWS;

    localparam int unsigned H_ACTIVE   = 640;
    localparam int unsigned V_ACTIVE   = 480;

    localparam int unsigned ADDR_W     = 11;
    localparam int unsigned CODE_W     = 8;
    localparam int unsigned ROW_W      = 5;
    localparam int unsigned LINE_W     = 5;

    localparam logic [CODE_W-1:0] CH_BLANK = 8'd0;
    localparam logic [CODE_W-1:0] CH_M     = 8'd1;
    localparam logic [CODE_W-1:0] CH_SOLID = 8'd2;
    localparam logic [CODE_W-1:0] CH_BOX   = 8'd3;
    localparam logic [CODE_W-1:0] CH_NINE  = 8'd4;

    // Per-pixel sideband carried beside the character/glyph reads.
    typedef struct packed {
        logic       active;
        logic       h_sync;
        logic       v_sync;
        logic [2:0] px;
        logic       cursor;
    } pix_side_t;

endpackage

// File: rtl/vga_font_rom.sv
// Glyph ROM: {code[2:0], line[3:0]} -> 8-pixel row, MSB leftmost, 1-cycle read.
// Ports: CLK; code (3b), line (4b) in; glyph (8b, registered) out.
// Codes: 0 blank, 1 'M', 2 solid, 3 box, 4 '9', 5..7 blank.
module vga_font_rom
    import vga_pkg::*;
(
    input  logic       CLK,
    input  logic [2:0] code,
    input  logic [3:0] line,
    output logic [7:0] glyph
);

    logic [7:0] glyph_c;

    // Glyph bitmap lookup
    always_comb begin
        glyph_c = 8'h00;
        case (code)
            3'(CH_BLANK): glyph_c = 8'h00;
            3'(CH_M): begin
                case (line)
                    4'd0:         glyph_c = 8'hC3;
                    4'd1:         glyph_c = 8'hE7;
                    4'd2:         glyph_c = 8'hFF;
                    4'd3:         glyph_c = 8'hDB;
                    4'd14, 4'd15: glyph_c = 8'h00;
                    default:      glyph_c = 8'hC3;
                endcase
            end
            3'(CH_SOLID): glyph_c = 8'hFF;
            3'(CH_BOX):   glyph_c = ((line == 4'd0) || (line == 4'd15)) ? 8'hFF : 8'h81;
            3'(CH_NINE): begin
                case (line)
                    4'd1:               glyph_c = 8'h3C;
                    4'd2, 4'd3, 4'd4:   glyph_c = 8'h66;
                    4'd5:               glyph_c = 8'h3E;
                    4'd6, 4'd7:         glyph_c = 8'h06;
                    4'd8:               glyph_c = 8'h0C;
                    4'd9:               glyph_c = 8'h38;
                    default:            glyph_c = 8'h00;
                endcase
            end
            default: glyph_c = 8'h00;
        endcase
    end

    always_ff @(posedge CLK) begin
        glyph <= glyph_c;
    end

endmodule

// File: rtl/vga_text_scanout.sv
// VGA text scan-out: owns the 80x24 character RAM, follows the timing
// generator's pixel coordinates and drives 1-bit RGB plus delayed syncs
// through a 3-cycle pipeline.
// Ports: CLK, reset (sync, active-high); h_count, v_count, active,
// h_sync_in, v_sync_in from the timing generator; write_char,
// write_char_pos, write_char_strobe cell write port; cursor_pos;
// red, green, blue, h_sync, v_sync registered outputs.
// Option: define VGA_CURSOR_EN for a blinking inverted cursor cell.
module vga_text_scanout
    import vga_pkg::*;
#(
    parameter logic [2:0] FG_COLOR = 3'b111,
    parameter logic [2:0] BG_COLOR = 3'b000
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic [9:0]        h_count,
    input  logic [9:0]        v_count,
    input  logic              active,
    input  logic              h_sync_in,
    input  logic              v_sync_in,
    input  logic [7:0]        write_char,
    input  logic [10:0]       write_char_pos,
    input  logic              write_char_strobe,
    input  logic [10:0]       cursor_pos,
    output logic              red,
    output logic              green,
    output logic              blue,
    output logic              h_sync,
    output logic              v_sync
);

    logic [CODE_W-1:0] char_ram [CHAR_COUNT];

    logic [ROW_W-1:0]  char_row, row_c;
    logic [LINE_W-1:0] cell_line, line_c;
    logic              frame_start_c, line_end_c;
    logic [ADDR_W-1:0] scan_addr_c, rd_addr_c;
    logic              cursor_hit_c;

    logic [CODE_W-1:0] ram_q;
    pix_side_t         s1_side, s2_side;
    logic [LINE_W-1:0] s1_line;
    logic              s2_blank;
    logic [2:0]        rom_code_c;
    logic [7:0]        rom_glyph;
    logic [7:0]        glyph_c;
    logic              pix_bit_c;
    logic [2:0]        colour_c;

    // The frame-start pixel must already see row/line 0, so bypass the regs
    assign frame_start_c = (v_count == '0) && (h_count == '0);
    assign line_end_c    = active && (h_count == 10'(H_ACTIVE - 1));
    assign row_c         = frame_start_c ? '0 : char_row;
    assign line_c        = frame_start_c ? '0 : cell_line;
    assign scan_addr_c   = ADDR_W'({row_c, 6'b0}) + ADDR_W'({row_c, 4'b0})
                         + ADDR_W'(h_count[9:3]);
    assign rd_addr_c     = active ? scan_addr_c : '0;

    // Row/line tracking by counting completed active lines
    always_ff @(posedge CLK) begin
        if (reset) begin
            char_row  <= '0;
            cell_line <= '0;
        end else if (frame_start_c) begin
            char_row  <= '0;
            cell_line <= '0;
        end else if (line_end_c) begin
            if (cell_line == LINE_W'(CELL_H - 1)) begin
                cell_line <= '0;
                if (char_row != ROW_W'(TEXT_ROWS - 1)) begin
                    char_row <= char_row + ROW_W'(1);
                end
            end else begin
                cell_line <= cell_line + LINE_W'(1);
            end
        end
    end

`ifdef VGA_CURSOR_EN
    logic [4:0] frame_cnt, frame_c;

    always_ff @(posedge CLK) begin
        if (reset) begin
            frame_cnt <= '0;
        end else if (frame_start_c) begin
            frame_cnt <= frame_cnt + 5'd1;
        end
    end

    assign frame_c      = frame_start_c ? (frame_cnt + 5'd1) : frame_cnt;
    assign cursor_hit_c = frame_c[4] && (cursor_pos < ADDR_W'(CHAR_COUNT))
                        && (cursor_pos == scan_addr_c);
`else
    logic unused_cursor;
    assign unused_cursor = ^cursor_pos;
    assign cursor_hit_c  = 1'b0;
`endif

    // Character RAM: read-before-write on a same-address collision
    always_ff @(posedge CLK) begin
        if (write_char_strobe && (write_char_pos < ADDR_W'(CHAR_COUNT))) begin
            char_ram[write_char_pos] <= write_char;
        end
        ram_q <= char_ram[rd_addr_c];
    end

    // Stage 1 sideband, aligned with the RAM read data
    always_ff @(posedge CLK) begin
        if (reset) begin
            s1_side <= '0;
            s1_line <= '0;
        end else begin
            s1_side <= '{active: active, h_sync: h_sync_in, v_sync: v_sync_in,
                         px: h_count[2:0], cursor: cursor_hit_c};
            s1_line <= line_c;
        end
    end

    // Codes 8 and above draw as a box
    assign rom_code_c = (ram_q[7:3] != '0) ? 3'(CH_BOX) : ram_q[2:0];

    vga_font_rom u_font_rom (
        .CLK   (CLK),
        .code  (rom_code_c),
        .line  (s1_line[3:0]),
        .glyph (rom_glyph)
    );

    // Stage 2 sideband, aligned with the ROM glyph row
    always_ff @(posedge CLK) begin
        if (reset) begin
            s2_side  <= '0;
            s2_blank <= 1'b0;
        end else begin
            s2_side  <= s1_side;
            s2_blank <= (s1_line >= LINE_W'(GLYPH_H));
        end
    end

    // Pixel select; cursor inversion covers the blank gap lines too
    assign glyph_c   = (s2_blank ? 8'h00 : rom_glyph) ^ {8{s2_side.cursor}};
    assign pix_bit_c = glyph_c[3'd7 - s2_side.px];
    assign colour_c  = s2_side.active ? (pix_bit_c ? FG_COLOR : BG_COLOR) : 3'b000;

    always_ff @(posedge CLK) begin
        if (reset) begin
            {red, green, blue} <= 3'b000;
            h_sync             <= 1'b0;
            v_sync             <= 1'b0;
        end else begin
            {red, green, blue} <= colour_c;
            h_sync             <= s2_side.h_sync;
            v_sync             <= s2_side.v_sync;
        end
    end

endmodule
